// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion and the combinational
// EX/MEM and MEM/WB forwarding muxes that feed the EX-stage ALU operands.
module id_ex_stage #(
    parameter int XLEN = 32,
    parameter int RW   = 5
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            stall_i,
    input  logic            flush_i,
    input  logic            id_valid,
    input  logic [RW-1:0]   id_rs1,
    input  logic [RW-1:0]   id_rs2,
    input  logic [RW-1:0]   id_rd,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic            id_alu_src,
    input  logic [3:0]      id_alu_cntrl,
    input  logic            id_reg_write,
    input  logic            id_mem_read,
    input  logic            id_mem_write,
    input  logic            id_mem_to_reg,
    input  logic [RW-1:0]   exm_rd,
    input  logic            exm_reg_write,
    input  logic [XLEN-1:0] exm_result,
    input  logic [RW-1:0]   mwb_rd,
    input  logic            mwb_reg_write,
    input  logic [XLEN-1:0] mwb_data,
    output logic            load_use_o,
    output logic            ex_valid,
    output logic [3:0]      alu_cntrl,
    output logic [XLEN-1:0] alu_in1,
    output logic [XLEN-1:0] alu_in2,
    output logic [XLEN-1:0] ex_store_data,
    output logic [RW-1:0]   ex_rd,
    output logic            ex_reg_write,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic            ex_mem_to_reg
);

    localparam logic [3:0] ALU_ADD = 4'b0010;

    logic            r_valid;
    logic [RW-1:0]   r_rs1;
    logic [RW-1:0]   r_rs2;
    logic [RW-1:0]   r_rd;
    logic [XLEN-1:0] r_rs1_data;
    logic [XLEN-1:0] r_rs2_data;
    logic [XLEN-1:0] r_imm;
    logic            r_alu_src;
    logic [3:0]      r_alu_cntrl;
    logic            r_reg_write;
    logic            r_mem_read;
    logic            r_mem_write;
    logic            r_mem_to_reg;

    logic            w_load_use;
    logic            w_rd_hits_rs1;
    logic            w_rd_hits_rs2;
    logic [XLEN-1:0] w_fwd_rs1;
    logic [XLEN-1:0] w_fwd_rs2;

    // rs2 only matters to the consumer when it feeds the ALU or is store data.
    assign w_rd_hits_rs1 = (r_rd == id_rs1);
    assign w_rd_hits_rs2 = (r_rd == id_rs2) && (!id_alu_src || id_mem_write);
    assign w_load_use    = r_valid && r_mem_read && (r_rd != '0) && id_valid
                           && (w_rd_hits_rs1 || w_rd_hits_rs2);

    // Bubbles only clear valid and the side-effecting controls; data is don't-care.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid      <= 1'b0;
            r_rs1        <= '0;
            r_rs2        <= '0;
            r_rd         <= '0;
            r_rs1_data   <= '0;
            r_rs2_data   <= '0;
            r_imm        <= '0;
            r_alu_src    <= 1'b0;
            r_alu_cntrl  <= ALU_ADD;
            r_reg_write  <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
        end else if (flush_i || (!stall_i && w_load_use)) begin
            r_valid      <= 1'b0;
            r_reg_write  <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
        end else if (!stall_i) begin
            r_valid      <= id_valid;
            r_rs1        <= id_rs1;
            r_rs2        <= id_rs2;
            r_rd         <= id_rd;
            r_rs1_data   <= id_rs1_data;
            r_rs2_data   <= id_rs2_data;
            r_imm        <= id_imm;
            r_alu_src    <= id_alu_src;
            r_alu_cntrl  <= id_alu_cntrl;
            r_reg_write  <= id_reg_write;
            r_mem_read   <= id_mem_read;
            r_mem_write  <= id_mem_write;
            r_mem_to_reg <= id_mem_to_reg;
        end
    end

    // EX/MEM is the younger producer, so it is tested first; x0 never forwards.
    always_comb begin
        w_fwd_rs1 = r_rs1_data;
        if (exm_reg_write && (exm_rd != '0) && (exm_rd == r_rs1)) begin
            w_fwd_rs1 = exm_result;
        end else if (mwb_reg_write && (mwb_rd != '0) && (mwb_rd == r_rs1)) begin
            w_fwd_rs1 = mwb_data;
        end
    end

    always_comb begin
        w_fwd_rs2 = r_rs2_data;
        if (exm_reg_write && (exm_rd != '0) && (exm_rd == r_rs2)) begin
            w_fwd_rs2 = exm_result;
        end else if (mwb_reg_write && (mwb_rd != '0) && (mwb_rd == r_rs2)) begin
            w_fwd_rs2 = mwb_data;
        end
    end

    assign load_use_o    = w_load_use;
    assign ex_valid      = r_valid;
    assign alu_cntrl     = r_alu_cntrl;
    assign alu_in1       = w_fwd_rs1;
    assign alu_in2       = r_alu_src ? r_imm : w_fwd_rs2;
    assign ex_store_data = w_fwd_rs2;
    assign ex_rd         = r_rd;
    assign ex_reg_write  = r_reg_write;
    assign ex_mem_read   = r_mem_read;
    assign ex_mem_write  = r_mem_write;
    assign ex_mem_to_reg = r_mem_to_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed hazard scenarios followed by
// randomized traffic compared against an instruction-level model of the EX slot.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        stall_i, flush_i, id_valid;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [31:0] id_rs1_data, id_rs2_data, id_imm;
    logic        id_alu_src;
    logic [3:0]  id_alu_cntrl;
    logic        id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
    logic [4:0]  exm_rd, mwb_rd;
    logic        exm_reg_write, mwb_reg_write;
    logic [31:0] exm_result, mwb_data;
    logic        load_use_o, ex_valid;
    logic [3:0]  alu_cntrl;
    logic [31:0] alu_in1, alu_in2, ex_store_data;
    logic [4:0]  ex_rd;
    logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;

    int checkCount = 0;
    int errorCount = 0;

    // The instruction currently sitting in EX, as the pipeline sees it.
    typedef struct {
        logic        valid;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] d1, d2, imm;
        logic        src;
        logic [3:0]  op;
        logic        rw, mr, mw, mtr;
    } exSlot_t;

    exSlot_t model;

    id_ex_stage #(.XLEN(32), .RW(5)) dut (
        .clk(clk), .reset_n(reset_n), .stall_i(stall_i), .flush_i(flush_i),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_alu_src(id_alu_src), .id_alu_cntrl(id_alu_cntrl),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
        .exm_rd(exm_rd), .exm_reg_write(exm_reg_write), .exm_result(exm_result),
        .mwb_rd(mwb_rd), .mwb_reg_write(mwb_reg_write), .mwb_data(mwb_data),
        .load_use_o(load_use_o), .ex_valid(ex_valid), .alu_cntrl(alu_cntrl),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .ex_store_data(ex_store_data),
        .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Value a source register reads as in EX: newest in-flight write wins, x0 stays 0.
    function automatic logic [31:0] operandValue(input logic [4:0] src, input logic [31:0] fileVal);
        if (src == 0) return fileVal;
        if (exm_reg_write && exm_rd == src) return exm_result;
        if (mwb_reg_write && mwb_rd == src) return mwb_data;
        return fileVal;
    endfunction

    function automatic logic expectLoadUse();
        logic needsRs2;
        needsRs2 = !id_alu_src || id_mem_write;
        return model.valid && model.mr && model.rd != 0 && id_valid &&
               (model.rd == id_rs1 || (needsRs2 && model.rd == id_rs2));
    endfunction

    task automatic compareAll();
        checkOutput("load_use", {31'b0, load_use_o}, {31'b0, expectLoadUse()});
        checkOutput("ex_valid", {31'b0, ex_valid}, {31'b0, model.valid});
        checkOutput("ctrl", {28'b0, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg},
                    {28'b0, model.rw, model.mr, model.mw, model.mtr});
        if (model.valid) begin
            checkOutput("alu_cntrl", {28'b0, alu_cntrl}, {28'b0, model.op});
            checkOutput("alu_in1", alu_in1, operandValue(model.rs1, model.d1));
            checkOutput("alu_in2", alu_in2,
                        model.src ? model.imm : operandValue(model.rs2, model.d2));
            checkOutput("store_data", ex_store_data, operandValue(model.rs2, model.d2));
            checkOutput("ex_rd", {27'b0, ex_rd}, {27'b0, model.rd});
        end
    endtask

    task automatic modelEdge();
        logic hazard;
        hazard = expectLoadUse();
        if (flush_i || (!stall_i && hazard)) begin
            model.valid = 0; model.rw = 0; model.mr = 0; model.mw = 0; model.mtr = 0;
        end else if (!stall_i) begin
            model = '{id_valid, id_rs1, id_rs2, id_rd, id_rs1_data, id_rs2_data, id_imm,
                      id_alu_src, id_alu_cntrl, id_reg_write, id_mem_read, id_mem_write,
                      id_mem_to_reg};
        end
    endtask

    // Check the current cycle, advance the model, and land on the next negedge.
    task automatic stepCycle();
        #1;
        compareAll();
        modelEdge();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic resetDut();
        reset_n = 1'b0;
        #1;
        checkOutput("rst_valid", {31'b0, ex_valid}, 32'd0);
        checkOutput("rst_ctrl", {28'b0, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg}, 32'd0);
        checkOutput("rst_cntrl", {28'b0, alu_cntrl}, 32'd2);
        checkOutput("rst_in1", alu_in1, 32'd0);
        checkOutput("rst_in2", alu_in2, 32'd0);
        model = '{1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0};
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic setInstr(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                            input logic [31:0] d1, input logic [31:0] d2, input logic memRead);
        id_valid = 1; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_rs1_data = d1; id_rs2_data = d2; id_imm = 32'h10;
        id_alu_src = 0; id_alu_cntrl = 4'b0010;
        id_reg_write = 1; id_mem_read = memRead; id_mem_write = 0; id_mem_to_reg = memRead;
    endtask

    task automatic applyStimulus();
        logic [3:0] ops [4];
        ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0110};
        stall_i       = ($urandom_range(0, 7) == 0);
        flush_i       = ($urandom_range(0, 7) == 0);
        id_valid      = ($urandom_range(0, 5) != 0);
        id_rs1        = 5'($urandom_range(0, 7));
        id_rs2        = 5'($urandom_range(0, 7));
        id_rd         = 5'($urandom_range(0, 7));
        id_rs1_data   = $urandom;
        id_rs2_data   = $urandom;
        id_imm        = $urandom;
        id_alu_src    = 1'($urandom);
        id_alu_cntrl  = ops[$urandom_range(0, 3)];
        id_reg_write  = 1'($urandom);
        id_mem_read   = ($urandom_range(0, 2) == 0);
        id_mem_write  = ($urandom_range(0, 3) == 0);
        id_mem_to_reg = 1'($urandom);
        exm_rd        = 5'($urandom_range(0, 7));
        exm_reg_write = 1'($urandom);
        exm_result    = $urandom;
        mwb_rd        = 5'($urandom_range(0, 7));
        mwb_reg_write = 1'($urandom);
        mwb_data      = $urandom;
    endtask

    initial begin
        reset_n = 1'b0;
        stall_i = 0; flush_i = 0;
        setInstr(5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 1'b0);
        id_valid = 0;
        exm_rd = 0; exm_reg_write = 0; exm_result = 0;
        mwb_rd = 0; mwb_reg_write = 0; mwb_data = 0;
        @(negedge clk);
        resetDut();

        // Plain ADD with no hazards.
        setInstr(5'd1, 5'd2, 5'd4, 32'd5, 32'd7, 1'b0);
        stepCycle();
        checkOutput("add_in1", alu_in1, 32'd5);
        checkOutput("add_in2", alu_in2, 32'd7);
        checkOutput("add_cntrl", {28'b0, alu_cntrl}, 32'd2);

        // Both forwarding sources target rs1; EX/MEM wins until it drops out.
        setInstr(5'd3, 5'd2, 5'd4, 32'd1, 32'd2, 1'b0);
        stepCycle();
        exm_rd = 3; exm_reg_write = 1; exm_result = 32'hAA;
        mwb_rd = 3; mwb_reg_write = 1; mwb_data = 32'hBB;
        #1 checkOutput("fwd_exm", alu_in1, 32'hAA);
        exm_reg_write = 0;
        #1 checkOutput("fwd_mwb", alu_in1, 32'hBB);

        // x0 is never forwarded.
        setInstr(5'd0, 5'd2, 5'd4, 32'd0, 32'd2, 1'b0);
        stepCycle();
        exm_rd = 0; exm_reg_write = 1; exm_result = 32'hFFFF;
        #1 checkOutput("x0_guard", alu_in1, 32'd0);
        exm_reg_write = 0; mwb_reg_write = 0;

        // lw x5 followed by add x6,x5,x1: one bubble, then the add issues.
        setInstr(5'd2, 5'd0, 5'd5, 32'd100, 32'd0, 1'b1);
        stepCycle();
        setInstr(5'd5, 5'd1, 5'd6, 32'd9, 32'd3, 1'b0);
        #1 checkOutput("lu_assert", {31'b0, load_use_o}, 32'd1);
        stepCycle();
        checkOutput("lu_bubble", {31'b0, ex_valid}, 32'd0);
        stepCycle();
        checkOutput("lu_issue", {31'b0, ex_valid}, 32'd1);
        checkOutput("lu_issue_rd", {27'b0, ex_rd}, 32'd6);

        // Flush beats stall; stall alone holds everything.
        flush_i = 1; stall_i = 1;
        stepCycle();
        checkOutput("flush_stall", {31'b0, ex_valid}, 32'd0);
        flush_i = 0; stall_i = 0;
        setInstr(5'd1, 5'd2, 5'd7, 32'd11, 32'd22, 1'b0);
        stepCycle();
        stall_i = 1;
        setInstr(5'd3, 5'd4, 5'd9, 32'd33, 32'd44, 1'b0);
        stepCycle();
        checkOutput("stall_valid", {31'b0, ex_valid}, 32'd1);
        checkOutput("stall_rd", {27'b0, ex_rd}, 32'd7);
        checkOutput("stall_in1", alu_in1, 32'd11);
        stall_i = 0;

        for (int cycle = 0; cycle < 3000; cycle++) begin
            applyStimulus();
            if ($urandom_range(0, 199) == 0) begin
                stall_i = 1;
                resetDut();
                stall_i = 0;
            end else begin
                stepCycle();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
